// File: rtl/alu_pkg.sv
// Shared constants, one-hot ALU op bit positions, pipe payload types and helpers
// for the alu_arbiter slice.
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 12;

  // One-hot ALU control bit positions. Shifts move src1 by src2[4:0];
  // lui places src2[15:0] in the upper half of the result.
  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // Issue register contents (S1).
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] src1;
    logic [ALU_W-1:0] src2;
    req_id_e          id;
  } issue_t;

  // Result register contents (S2).
  typedef struct packed {
    logic [ALU_W-1:0] data;
    req_id_e          id;
    logic             err;
  } result_t;

  // True when exactly one control bit is set.
  function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - OP_W'(1))) == '0);
  endfunction

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, result and statistics signals of alu_arbiter. The master modport is
// the environment (requesters + result consumer); the slave modport is the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [ALU_W-1:0] req0_src1;
  logic [ALU_W-1:0] req0_src2;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [ALU_W-1:0] req1_src1;
  logic [ALU_W-1:0] req1_src2;

  logic             res_valid;
  logic             res_ready;
  logic [ALU_W-1:0] res_data;
  logic             res_id;
  logic             res_err;

  logic [ALU_W-1:0] op_count;

  modport master (
    output req0_valid, req0_op, req0_src1, req0_src2,
    output req1_valid, req1_op, req1_src1, req1_src2,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, res_err, op_count
  );

  modport slave (
    input  req0_valid, req0_op, req0_src1, req0_src2,
    input  req1_valid, req1_op, req1_src1, req1_src2,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, res_err, op_count
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational one-hot ALU. Every selected operation's result is OR-ed into the
// output, so a zero control gives 0 and a multi-hot control gives the OR of the selections.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  alu_control,
  input  logic [ALU_W-1:0] alu_src1,
  input  logic [ALU_W-1:0] alu_src2,
  output logic [ALU_W-1:0] alu_result
);

  logic [4:0]       shamt;
  logic [ALU_W-1:0] add_r, sub_r, slt_r, sltu_r;
  logic [ALU_W-1:0] and_r, nor_r, or_r, xor_r;
  logic [ALU_W-1:0] sll_r, srl_r, sra_r, lui_r;

  assign shamt  = alu_src2[4:0];

  assign add_r  = alu_src1 + alu_src2;
  assign sub_r  = alu_src1 - alu_src2;
  assign slt_r  = {{(ALU_W-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
  assign sltu_r = {{(ALU_W-1){1'b0}}, alu_src1 < alu_src2};
  assign and_r  = alu_src1 & alu_src2;
  assign nor_r  = ~(alu_src1 | alu_src2);
  assign or_r   = alu_src1 | alu_src2;
  assign xor_r  = alu_src1 ^ alu_src2;
  assign sll_r  = alu_src1 << shamt;
  assign srl_r  = alu_src1 >> shamt;
  assign sra_r  = $unsigned($signed(alu_src1) >>> shamt);
  assign lui_r  = {alu_src2[15:0], 16'h0000};

  assign alu_result = ({ALU_W{alu_control[OP_ADD]}}  & add_r)
                    | ({ALU_W{alu_control[OP_SUB]}}  & sub_r)
                    | ({ALU_W{alu_control[OP_SLT]}}  & slt_r)
                    | ({ALU_W{alu_control[OP_SLTU]}} & sltu_r)
                    | ({ALU_W{alu_control[OP_AND]}}  & and_r)
                    | ({ALU_W{alu_control[OP_NOR]}}  & nor_r)
                    | ({ALU_W{alu_control[OP_OR]}}   & or_r)
                    | ({ALU_W{alu_control[OP_XOR]}}  & xor_r)
                    | ({ALU_W{alu_control[OP_SLL]}}  & sll_r)
                    | ({ALU_W{alu_control[OP_SRL]}}  & srl_r)
                    | ({ALU_W{alu_control[OP_SRA]}}  & sra_r)
                    | ({ALU_W{alu_control[OP_LUI]}}  & lui_r);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU: S1 issue register, ALU,
// S2 result register, delivered-result counter. Define ALU_ARB_OPCHK_EN to flag non-one-hot ops.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic             s1_valid;
  issue_t           s1_q;
  issue_t           s1_d;
  logic             s2_valid;
  result_t          s2_q;
  result_t          s2_d;
  logic [ALU_W-1:0] alu_result;
  logic [ALU_W-1:0] op_count_q;

  req_id_e          last_grant;
  req_id_e          grant;
  logic             s2_can_load;
  logic             s1_can_load;
  logic             accept;
  logic             res_fire;

  // Pipe control: S2 frees up when empty or draining, S1 when empty or advancing.
  assign s2_can_load = !s2_valid || bus.res_ready;
  assign s1_can_load = (!s1_valid || s2_can_load) && !reset;
  assign res_fire    = s2_valid && bus.res_ready;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant = other_req(last_grant);
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = REQ0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = REQ1;
    end
  end

  assign bus.req0_ready = s1_can_load && (grant == REQ0);
  assign bus.req1_ready = s1_can_load && (grant == REQ1);
  assign accept = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);

  always_comb begin
    s1_d.op   = bus.req0_op;
    s1_d.src1 = bus.req0_src1;
    s1_d.src2 = bus.req0_src2;
    s1_d.id   = grant;
    if (grant == REQ1) begin
      s1_d.op   = bus.req1_op;
      s1_d.src1 = bus.req1_src1;
      s1_d.src2 = bus.req1_src2;
    end
  end

  // Pointer moves only on an accepted transfer; reset favours requester 0.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_can_load) begin
      s1_valid <= accept;
    end
  end

  // NOTE: the S1 payload is not reset; it is only observed behind s1_valid,
  // which is, so resetting the wide datapath would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q <= s1_d;
    end
  end

  alu u_alu (
    .alu_control (s1_q.op),
    .alu_src1    (s1_q.src1),
    .alu_src2    (s1_q.src2),
    .alu_result  (alu_result)
  );

  always_comb begin
    s2_d.id = s1_q.id;
`ifdef ALU_ARB_OPCHK_EN
    s2_d.err  = !op_is_onehot(s1_q.op);
    s2_d.data = s2_d.err ? '0 : alu_result;
`else
    s2_d.err  = 1'b0;
    s2_d.data = alu_result;
`endif
  end

  // S2 holds its contents while the consumer stalls, keeping the result stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q <= s2_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (res_fire) begin
      op_count_q <= op_count_q + ALU_W'(1);
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_q.data;
  assign bus.res_id    = s2_q.id;
  assign bus.res_err   = s2_q.err;
  assign bus.op_count  = op_count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; ALU_W = 32 and OP_W = 12 are fixed constants from alu_pkg.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_op / req1_op  input  12 each  one-hot ALU control: bit11 add … bit0 lui.
REQ-007 req0_src1, req0_src2, req1_src1, req1_src2  input  32 each  operands.
REQ-008 res_valid  output  1  result register holds a result.
REQ-009 res_ready  input  1  consumer takes the result.
REQ-010 res_data  output  32  ALU result.
REQ-011 res_id  output  1  requester index that issued the result.
REQ-012 res_err  output  1  op was not one-hot (see Configuration).
REQ-013 op_count  output  32  number of results delivered.

Function
REQ-014 Two-stage pipe: S1 (issue register: op, src1, src2, id) feeding one shared alu instance, then S2 (result register: data, id, err).
REQ-015 Transfer on a channel only when valid and ready are both high on the same edge; a requester's valid never depends on its ready.
REQ-016 S1 can load when S1 is empty, or when S1 advances to S2 in the same cycle.
REQ-017 S1 advances to S2 when S2 is empty or res_ready=1.
REQ-018 Arbitration is round-robin: one valid requester wins; both valid means the requester not granted last wins.
REQ-019 reqN_ready = (S1 can load) AND (grant = N); ready is never asserted for both requesters in one cycle.
REQ-020 The last-grant pointer updates only on an accepted transfer; a stalled grant holds its winner.
REQ-021 Latency: an op accepted at edge N gives res_valid=1 after edge N+1; with res_ready held high, throughput is 1 op/cycle.
REQ-022 While res_valid=1 and res_ready=0, res_data/res_id/res_err stay stable, S1 holds, and both ready outputs are 0 if S1 is full.
REQ-023 op_count increments by 1 on each res_valid & res_ready edge and wraps from 0xFFFFFFFF to 0.
REQ-024 Simultaneous S2 drain, S1 advance and new accept in one cycle SHALL lose no operation.

Reset
REQ-025 reset=1 clears the S1 and S2 valid bits; res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0.
REQ-026 Reset sets the pointer so requester 0 wins the first contention.
REQ-027 Reset mid-operation discards in-flight ops, with no result delivered for them; ready is 0 during reset.

Configuration
REQ-028 With ALU_ARB_OPCHK_EN defined, an op whose control is not exactly one-hot (zero or ≥2 bits) is still accepted; it yields res_data=0 and res_err=1.
REQ-029 Without ALU_ARB_OPCHK_EN, res_err is tied 0 and res_data is the raw alu output for any control value.

Structure
REQ-030 alu_pkg holds: ALU_W, OP_W, the one-hot op bit indices (OP_ADD=11 … OP_LUI=0), and the onehot-check function.
REQ-031 A single sub-module, alu (control/src1/src2 -> result, combinational), is instantiated once between S1 and S2; the arbiter, pipe registers and counter live in alu_arbiter.

Verification
REQ-032 Single add: req0 op=add(bit11), 5+3, res_ready=1 -> res_valid two edges after accept, res_data=8, res_id=0, op_count=1.
REQ-033 Sub wrap: req1 op=sub, 3-5 -> res_data=0xFFFFFFFE, res_id=1.
REQ-034 Contention: both valid continuously for 6 ops, res_ready=1 -> res_id sequence 0,1,0,1,0,1; one accept per cycle.
REQ-035 Backpressure: res_ready=0 for 5 cycles with 3 ops offered -> 2 accepted, then both ready=0; res_data stable; after release all 3 results arrive in order.
REQ-036 OPCHK (macro defined): op=0x0C0 -> res_err=1, res_data=0; without the macro, res_err=0.
REQ-037 Reset mid-stream with S1 and S2 full -> next cycle res_valid=0 and op_count=0; the first subsequent contention is granted to requester 0.
